elevator_controller: RTL and testbench
======================================

# elevator_controller

Car controller for the three-floor elevator. It latches hall/car calls from three buttons and drives the pending-request lamps `led1`..`led3`, which feed the tick generator. It consumes that generator's slow `tick` to step the car one floor per tick edge and to time the door. It outputs the current floor, the direction and the door state to the display logic.

## Interface
Parameters:
- `DOOR_TICKS`, default 3: tick edges the door stays open; legal range 1..15.

Ports:
- `clk_50`  in  1  system clock, 50 MHz; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn`  in  3  call buttons, already debounced and synchronous to `clk_50`; `btn[i]` requests floor i.
- `tick`  in  1  slow clock from the tick generator; only its rising edge is used.
- `led1`, `led2`, `led3`  out  1 each  pending request for floor 0, 1, 2; registered.
- `floor`  out  2  current floor, 0..2; value 3 is never driven.
- `dir_up`, `dir_down`  out  1 each  the car is in MOVE_UP or MOVE_DOWN; mutually exclusive.
- `door_open`  out  1  high while in DOOR_OPEN.

## Operation
- Edge detection:
  - Registers `btn_q[2:0]` and `tick_q`, both reset to 0.
  - `press[i] = btn[i] & ~btn_q[i]`.
  - `tstep = tick & ~tick_q`.
  - Holding a button produces exactly one press.
- Request latch `req[2:0]`, mapped to `{led3, led2, led1}`:
  - A press sets `req[i]`.
  - `req[i]` clears on the cycle the FSM enters DOOR_OPEN at floor i.
  - Press and clear for the same floor in the same cycle: clear wins.
  - A press for the current floor while in DOOR_OPEN is not latched. It reloads the door counter to `DOOR_TICKS`.
- `last_dir` register, reset to up: records the most recent movement direction and is used for SCAN preference.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. The state encoding is internal.
- IDLE, evaluated every cycle:
  - `req[floor]` set → DOOR_OPEN.
  - Otherwise, if requests exist above and below the car, go in the `last_dir` direction.
  - Otherwise, any request above → MOVE_UP; any request below → MOVE_DOWN.
  - Otherwise stay in IDLE.
- MOVE_UP, on `tstep`:
  - `floor <= floor+1` and `last_dir <= up`.
  - If `req[floor+1]` is set → DOOR_OPEN.
  - Else if any request lies above `floor+1` → stay in MOVE_UP.
  - Else → IDLE.
- MOVE_DOWN: mirror image of MOVE_UP.
- Floor saturation is guaranteed by the decisions above: MOVE_UP is never entered at floor 2 and MOVE_DOWN never at floor 0. A floor value outside 0..2 is a bug.
- DOOR_OPEN:
  - Entry loads the 4-bit `door_cnt` with `DOOR_TICKS`.
  - Each `tstep` decrements `door_cnt`.
  - When `tstep` arrives with `door_cnt == 1` → IDLE.
  - Calls for other floors are latched meanwhile.
- Requests latched while moving are served by the decision rules above; a moving car never reverses mid-run.

## Timing
- Reset (`rst` sampled high at a `clk_50` edge) forces:
  - State IDLE, `floor=0`, `req=0`, so `led1..3` are 0.
  - `door_open=0`, `dir_up=0`, `dir_down=0`, `door_cnt=0`, `last_dir=up`, `btn_q=0`, `tick_q=0`.
  - This holds mid-move and mid-door, with no residual outputs.
- Button to lamp: the `led` rises on the edge that samples the press; the lamp is visible 1 cycle after `btn` goes high.
- Request to state: IDLE decides on the cycle after `req` is set. `dir_up`/`dir_down`/`door_open` are valid 2 cycles after the press.
- Floor step: `floor` updates on the same `clk_50` edge that detects `tstep`; the next state is taken on that edge.
- Door time: exactly `DOOR_TICKS` tick rising edges after entry, counting from the first tick edge strictly after the entry cycle.
- `tick` held high produces one step only; `tick` high during reset produces no step after reset releases.
- A press and `tstep` in the same cycle are both honoured: the press is latched and the step is taken.
- All outputs are registered, with no combinational paths from input to output.

## Test plan
- Reset: assert `rst` 2 cycles mid-MOVE_UP with `req=3'b110` → next cycle `floor=0`, `led1..3=0`, `dir_up=0`, `door_open=0`.
- Single call: from reset, pulse `btn[2]` → `led3=1` next cycle; `dir_up=1` one cycle later; after 2 tick edges `floor=2`, `door_open=1`, `led3=0`. After 3 more tick edges `door_open=0` and the FSM is in IDLE.
- Same-floor call: idle at floor 0, press `btn[0]` → `door_open=1` 2 cycles later and `led1` is never observed high for more than 1 cycle.
- Door extend: in DOOR_OPEN at floor 1, press `btn[1]` after 2 tick edges → door stays open 3 further tick edges; `led2` stays 0.
- SCAN preference: car at floor 1, `last_dir=up`, press `btn[0]` and `btn[2]` in the same cycle → MOVE_UP first, serve floor 2, then MOVE_DOWN to floor 0.
- Held inputs: hold `btn[1]` high for 100 cycles and hold `tick` high for 50 cycles → one request, one floor step.

Source files
------------

// File: rtl/elevator_controller.sv
// elevator_controller: three-floor car controller.
// Latches calls from three buttons, steps the car one floor per rising edge
// of the slow tick, times the door, and reports floor, direction and door.
//
// Handshake-free block: every input is a level that is edge-detected
// internally. A button or tick rising edge is acted on in the clk_50 cycle
// that first sees it high, and each rising edge is acted on exactly once.
module elevator_controller #(
  parameter int DOOR_TICKS = 3
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic       tick,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] floor,
  output logic       dir_up,
  output logic       dir_down,
  output logic       door_open
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam logic [3:0] DOOR_LOAD = 4'(DOOR_TICKS);

  state_e     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [2:0] req_q, req_d;
  logic [2:0] btn_q, btn_d;
  logic       tick_q, tick_d;
  logic       last_up_q, last_up_d;
  logic [3:0] door_cnt_q, door_cnt_d;
  logic       dir_up_q, dir_up_d;
  logic       dir_down_q, dir_down_d;
  logic       door_open_q, door_open_d;

  logic [2:0] press;
  logic       tstep;
  logic [2:0] req_set;
  logic [2:0] req_clr;

  // One-hot mask for a floor number; floor 3 never occurs and maps to none.
  function automatic logic [2:0] floor_mask(input logic [1:0] f);
    logic [2:0] m;
    case (f)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // True when a request is pending strictly above floor f.
  function automatic logic any_above(input logic [2:0] r, input logic [1:0] f);
    logic a;
    case (f)
      2'd0:    a = r[1] | r[2];
      2'd1:    a = r[2];
      default: a = 1'b0;
    endcase
    return a;
  endfunction

  // True when a request is pending strictly below floor f.
  function automatic logic any_below(input logic [2:0] r, input logic [1:0] f);
    logic b;
    case (f)
      2'd1:    b = r[0];
      2'd2:    b = r[0] | r[1];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Next-state, request latch, door timer and registered-output decode.
  always_comb begin
    press       = btn & ~btn_q;
    tstep       = tick & ~tick_q;
    btn_d       = btn;
    tick_d      = tick;
    state_d     = state_q;
    floor_d     = floor_q;
    last_up_d   = last_up_q;
    door_cnt_d  = door_cnt_q;
    req_set     = press;
    req_clr     = 3'b000;

    case (state_q)
      IDLE: begin
        if ((req_q & floor_mask(floor_q)) != 3'b000) begin
          state_d = DOOR_OPEN;
        end else if (any_above(req_q, floor_q) && any_below(req_q, floor_q)) begin
          // Calls on both sides: keep sweeping the way we last moved.
          state_d = last_up_q ? MOVE_UP : MOVE_DOWN;
        end else if (any_above(req_q, floor_q)) begin
          state_d = MOVE_UP;
        end else if (any_below(req_q, floor_q)) begin
          state_d = MOVE_DOWN;
        end
      end

      MOVE_UP: begin
        if (tstep) begin
          if (floor_q >= 2'd2) begin
            // Unreachable by construction; park rather than overflow.
            state_d = IDLE;
          end else begin
            floor_d   = floor_q + 2'd1;
            last_up_d = 1'b1;
            if ((req_q & floor_mask(floor_d)) != 3'b000) begin
              state_d = DOOR_OPEN;
            end else if (any_above(req_q, floor_d)) begin
              state_d = MOVE_UP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      MOVE_DOWN: begin
        if (tstep) begin
          if (floor_q == 2'd0) begin
            // Unreachable by construction; park rather than underflow.
            state_d = IDLE;
          end else begin
            floor_d   = floor_q - 2'd1;
            last_up_d = 1'b0;
            if ((req_q & floor_mask(floor_d)) != 3'b000) begin
              state_d = DOOR_OPEN;
            end else if (any_below(req_q, floor_d)) begin
              state_d = MOVE_DOWN;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      DOOR_OPEN: begin
        if ((press & floor_mask(floor_q)) != 3'b000) begin
          // Passenger at this floor holds the door: restart the timer and
          // do not light the lamp for a floor already being served.
          door_cnt_d = DOOR_LOAD;
          req_set    = press & ~floor_mask(floor_q);
        end else if (tstep) begin
          if (door_cnt_q <= 4'd1) begin
            door_cnt_d = 4'd0;
            state_d    = IDLE;
          end else begin
            door_cnt_d = door_cnt_q - 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Entering DOOR_OPEN serves the floor: load the timer, drop the call.
    if (state_d == DOOR_OPEN && state_q != DOOR_OPEN) begin
      door_cnt_d = DOOR_LOAD;
      req_clr    = floor_mask(floor_d);
    end

    // Clear beats a same-cycle press for the same floor.
    req_d = (req_q | req_set) & ~req_clr;

    dir_up_d    = (state_d == MOVE_UP);
    dir_down_d  = (state_d == MOVE_DOWN);
    door_open_d = (state_d == DOOR_OPEN);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q     <= IDLE;
      floor_q     <= 2'd0;
      req_q       <= 3'b000;
      btn_q       <= 3'b000;
      tick_q      <= 1'b0;
      last_up_q   <= 1'b1;
      door_cnt_q  <= 4'd0;
      dir_up_q    <= 1'b0;
      dir_down_q  <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      req_q       <= req_d;
      btn_q       <= btn_d;
      tick_q      <= tick_d;
      last_up_q   <= last_up_d;
      door_cnt_q  <= door_cnt_d;
      dir_up_q    <= dir_up_d;
      dir_down_q  <= dir_down_d;
      door_open_q <= door_open_d;
    end
  end

  assign led1      = req_q[0];
  assign led2      = req_q[1];
  assign led3      = req_q[2];
  assign floor     = floor_q;
  assign dir_up    = dir_up_q;
  assign dir_down  = dir_down_q;
  assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed scenarios with hand-computed expectations
// for the three-floor elevator controller (DOOR_TICKS = 3).
module tb_elevator_controller;

  logic       clk_50;
  logic       rst;
  logic [2:0] btn;
  logic       tick;
  logic       led1, led2, led3;
  logic [1:0] floor;
  logic       dir_up, dir_down, door_open;

  int n_checks;
  int n_pass;

  elevator_controller #(.DOOR_TICKS(3)) dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .btn       (btn),
    .tick      (tick),
    .led1      (led1),
    .led2      (led2),
    .led3      (led3),
    .floor     (floor),
    .dir_up    (dir_up),
    .dir_down  (dir_down),
    .door_open (door_open)
  );

  // Clock: 50 MHz.
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One tick rising edge seen by the DUT, then tick back low.
  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic tick_pulses(input int n);
    for (int i = 0; i < n; i++) tick_pulse();
  endtask

  // Press a set of buttons for exactly one clock.
  task automatic press(input logic [2:0] b);
    btn = b;
    step();
    btn = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] leds();
    return {led3, led2, led1};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst  = 1'b1;
    btn  = 3'b000;
    tick = 1'b0;
    steps(2);
    rst = 1'b0;

    // Reset state.
    check("rst_floor", 8'(floor), 8'd0);
    check("rst_leds", 8'(leds()), 8'd0);
    check("rst_dirs", 8'({dir_up, dir_down, door_open}), 8'd0);

    // Single call to floor 2.
    press(3'b100);
    check("call_led3", 8'(leds()), 8'b100);
    check("call_dir_early", 8'(dir_up), 8'd0);
    step();
    check("call_dir_up", 8'(dir_up), 8'd1);
    tick_pulse();
    check("call_floor1", 8'(floor), 8'd1);
    check("call_passing", 8'({dir_up, door_open}), 8'b10);
    tick_pulse();
    check("call_floor2", 8'(floor), 8'd2);
    check("call_door", 8'({dir_up, dir_down, door_open}), 8'b001);
    check("call_led3_clr", 8'(leds()), 8'd0);
    tick_pulses(2);
    check("call_door_held", 8'(door_open), 8'd1);
    tick_pulse();
    check("call_idle", 8'({dir_up, dir_down, door_open}), 8'd0);
    check("call_idle_floor", 8'(floor), 8'd2);

    // Same-floor call at floor 0.
    do_reset();
    press(3'b001);
    check("same_led1", 8'(leds()), 8'b001);
    check("same_door_early", 8'(door_open), 8'd0);
    step();
    check("same_door", 8'(door_open), 8'd1);
    check("same_led1_clr", 8'(leds()), 8'd0);
    tick_pulses(3);
    check("same_closed", 8'(door_open), 8'd0);

    // Door extend at floor 1.
    press(3'b010);
    step();
    check("ext_dir_up", 8'(dir_up), 8'd1);
    tick_pulse();
    check("ext_arrive", 8'({floor, door_open}), 8'b011);
    tick_pulses(2);
    check("ext_open_2", 8'(door_open), 8'd1);
    press(3'b010);
    check("ext_led2_off", 8'(leds()), 8'd0);
    tick_pulses(2);
    check("ext_still_open", 8'(door_open), 8'd1);
    tick_pulse();
    check("ext_closed", 8'(door_open), 8'd0);
    check("ext_led2_never", 8'(leds()), 8'd0);

    // SCAN preference at floor 1 after moving up.
    press(3'b101);
    check("scan_leds", 8'(leds()), 8'b101);
    step();
    check("scan_up_first", 8'({dir_up, dir_down}), 8'b10);
    tick_pulse();
    check("scan_at2", 8'({floor, door_open}), 8'b101);
    check("scan_leds_at2", 8'(leds()), 8'b001);
    tick_pulses(3);
    check("scan_down", 8'({dir_up, dir_down, door_open}), 8'b010);
    tick_pulse();
    check("scan_pass1", 8'({floor, dir_down}), 8'b011);
    tick_pulse();
    check("scan_at0", 8'({floor, door_open}), 8'b001);
    check("scan_leds_done", 8'(leds()), 8'd0);
    tick_pulses(3);
    check("scan_idle", 8'({dir_up, dir_down, door_open}), 8'd0);

    // Held inputs: btn[1] 100 cycles, tick 50 cycles.
    btn = 3'b010;
    step();
    check("held_led2", 8'(leds()), 8'b010);
    step();
    tick = 1'b1;
    steps(50);
    tick = 1'b0;
    steps(48);
    btn = 3'b000;
    step();
    check("held_floor", 8'(floor), 8'd1);
    check("held_door", 8'(door_open), 8'd1);
    check("held_leds", 8'(leds()), 8'd0);

    // Reset mid-MOVE_UP with two calls pending.
    do_reset();
    press(3'b110);
    step();
    check("mid_moving", 8'({dir_up, leds()}), 8'b1110);
    do_reset();
    check("mid_rst_floor", 8'(floor), 8'd0);
    check("mid_rst_leds", 8'(leds()), 8'd0);
    check("mid_rst_outs", 8'({dir_up, dir_down, door_open}), 8'd0);

    // tick and btn[2] held through reset: a call, but no floor step.
    tick = 1'b1;
    btn  = 3'b100;
    do_reset();
    steps(4);
    check("rtick_dir_up", 8'(dir_up), 8'd1);
    check("rtick_floor", 8'(floor), 8'd0);
    tick = 1'b0;
    btn  = 3'b000;
    step();
    // Press for floor 2 in the same cycle as the step to floor 1.
    tick = 1'b1;
    press(3'b100);
    tick = 1'b0;
    check("rtick_step", 8'(floor), 8'd1);
    step();
    tick_pulse();
    check("rtick_at2", 8'({floor, door_open}), 8'b101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
